// File: rtl/scan_pkg.sv
// Shared definitions for the decoder scan controller: FSM encoding and
// decoder enable codes.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DWELL = 2'd2
    } scan_state_e;

    localparam logic [2:0] EN_ACTIVE = 3'b100;
    localparam logic [2:0] EN_OFF    = 3'b000;

endpackage

// File: rtl/next_chan_sel.sv
// Finds the next unmasked channel above cur_i, wrapping 7->0; cur_i itself is
// the last candidate, so a single unmasked channel selects itself with wrap_o.
module next_chan_sel (
    input  logic [2:0] cur_i,
    input  logic [7:0] mask_i,
    output logic [2:0] nxt_o,
    output logic       wrap_o,
    output logic       none_o
);

    logic [2:0] cand;
    logic       found;

    always_comb begin
        nxt_o = cur_i;
        cand  = cur_i;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cand = cur_i + 3'(i);
            if (!found && !mask_i[cand]) begin
                nxt_o = cand;
                found = 1'b1;
            end
        end
    end

    assign wrap_o = (nxt_o <= cur_i);
    assign none_o = &mask_i;

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scans decoder channels 0..7 with a blanking gap before each channel and a
// programmable dwell, skipping masked channels; continuous or single sweep.
module decoder_scan_ctrl
    import scan_pkg::*;
#(
    parameter int DWELL_W   = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               mode_i,
    input  logic [7:0]         mask_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [2:0]         data_o,
    output logic [2:0]         en_o,
    output logic               busy_o,
    output logic               sweep_done_o
);

    localparam int BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLANK_CYC - 1);

    scan_state_e        state_q, state_d;
    logic [2:0]         data_q, data_d;
    logic [2:0]         en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               mode_q, mode_d;
    logic [BLK_W-1:0]   blank_q, blank_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic [2:0]         sel_cur, sel_nxt;
    logic               sel_wrap, sel_none;
    logic [DWELL_W-1:0] dwell_load;

    // From IDLE, searching above channel 7 yields the lowest unmasked channel.
    assign sel_cur    = (state_q == IDLE) ? 3'd7 : data_q;
    assign dwell_load = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;

    next_chan_sel u_sel (
        .cur_i  (sel_cur),
        .mask_i (mask_i),
        .nxt_o  (sel_nxt),
        .wrap_o (sel_wrap),
        .none_o (sel_none)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        done_d  = 1'b0;
        mode_d  = mode_q;
        blank_d = blank_q;
        dwell_d = dwell_q;
        case (state_q)
            IDLE: begin
                if (start_i && !stop_i && !sel_none) begin
                    state_d = BLANK;
                    data_d  = sel_nxt;
                    blank_d = BLK_LOAD;
                    mode_d  = mode_i;
                end
            end
            BLANK: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (blank_q == '0) begin
                    state_d = DWELL;
                    dwell_d = dwell_load;
                end else begin
                    blank_d = blank_q - BLK_W'(1);
                end
            end
            DWELL: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (dwell_q <= DWELL_W'(1)) begin
                    if (sel_none || (sel_wrap && mode_q)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        done_d  = sel_wrap;
                        state_d = BLANK;
                        data_d  = sel_nxt;
                        blank_d = BLK_LOAD;
                    end
                end else begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        en_d   = (state_d == DWELL) ? EN_ACTIVE : EN_OFF;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= 3'd0;
            en_q    <= EN_OFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 1'b0;
            blank_q <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            blank_q <= blank_d;
            dwell_q <= dwell_d;
        end
    end

    assign data_o       = data_q;
    assign en_o         = en_q;
    assign busy_o       = busy_q;
    assign sweep_done_o = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: single-sweep vector table plus
// hand-written continuous, stop, start-while-busy and async-reset sequences.
module tb_decoder_scan_ctrl;
    import scan_pkg::*;

    localparam int BLANK_CYC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        mode_i = 1'b1;
    logic [7:0]  mask_i = 8'h00;
    logic [15:0] dwell_i = 16'd1;
    logic [2:0]  data_o;
    logic [2:0]  en_o;
    logic        busy_o;
    logic        sweep_done_o;

    int n_cmp = 0;
    int n_bad = 0;

    decoder_scan_ctrl #(.DWELL_W(16), .BLANK_CYC(BLANK_CYC)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .mode_i       (mode_i),
        .mask_i       (mask_i),
        .dwell_i      (dwell_i),
        .data_o       (data_o),
        .en_o         (en_o),
        .busy_o       (busy_o),
        .sweep_done_o (sweep_done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // 3-to-8 decoder model driven by the controller outputs
    logic [7:0] dec;
    assign dec = (en_o == 3'b100) ? (8'b1 << data_o) : 8'h00;

    logic [2:0] prev_data = 3'd0;
    logic [2:0] prev_en   = 3'd0;
    always @(negedge clk) begin
        if (!rst) begin
            chk("en_legal", 32'(en_o == 3'b100 || en_o == 3'b000), 32'd1);
            if (prev_en == 3'b100 && en_o == 3'b100)
                chk("data_stable_in_dwell", 32'(data_o), 32'(prev_data));
            if (dec != 8'h00)
                chk("decoded_only_when_busy", 32'(busy_o), 32'd1);
            else if (busy_o && en_o == 3'b100)
                chk("decoded_line_missing", 32'(dec), 32'(8'b1 << data_o));
        end
        prev_data = data_o;
        prev_en   = en_o;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Follows one channel starting on its first BLANK cycle.
    task automatic observe_chan(input string tag, input logic [2:0] ch, input int dw,
                                input bit done_exp, input bit busy_exp);
        int blank = 0;
        int dwl = 0;
        int guard = 0;
        logic [2:0] dch = 3'd0;
        while (busy_o && en_o == 3'b000 && guard < 64) begin
            chk({tag, "_blank_data"}, 32'(data_o), 32'(ch));
            blank++; guard++;
            @(negedge clk);
        end
        dch = data_o;
        while (en_o == 3'b100 && guard < 64) begin
            dwl++; guard++;
            @(negedge clk);
        end
        chk({tag, "_timeout"}, 32'(guard < 64), 32'd1);
        chk({tag, "_blank_len"}, 32'(blank), 32'(BLANK_CYC));
        chk({tag, "_dwell_data"}, 32'(dch), 32'(ch));
        chk({tag, "_dwell_len"}, 32'(dwl), 32'(dw));
        chk({tag, "_done"}, 32'(sweep_done_o), 32'(done_exp));
        chk({tag, "_busy_after"}, 32'(busy_o), 32'(busy_exp));
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_en_active(input string tag);
        int guard = 0;
        while (en_o != 3'b100 && guard < 64) begin
            guard++;
            @(negedge clk);
        end
        chk({tag, "_wait_en"}, 32'(guard < 64), 32'd1);
    endtask

    typedef struct {
        logic [7:0]      mask;
        logic [15:0]     dwell;
        int              n_ch;
        logic [7:0][2:0] chans;
        int              exp_dw;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h00, 16'd3, 8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 3};
        vecs[1] = '{8'hAA, 16'd1, 4, {3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd4, 3'd2, 3'd0}, 1};
        vecs[2] = '{8'hF7, 16'd0, 1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3}, 1};
        vecs[3] = '{8'h7E, 16'd2, 2, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd0}, 2};
        vecs[4] = '{8'h01, 16'd2, 7, {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, 2};

        @(negedge clk);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_en", 32'(en_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(sweep_done_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single-sweep table
        for (int v = 0; v < 5; v++) begin
            mask_i  = vecs[v].mask;
            dwell_i = vecs[v].dwell;
            mode_i  = 1'b1;
            pulse_start();
            chk($sformatf("v%0d_busy_after_start", v), 32'(busy_o), 32'd1);
            chk($sformatf("v%0d_en_after_start", v), 32'(en_o), 32'd0);
            for (int k = 0; k < vecs[v].n_ch; k++)
                observe_chan($sformatf("v%0d_ch%0d", v, k), vecs[v].chans[k], vecs[v].exp_dw,
                             k == vecs[v].n_ch - 1, k != vecs[v].n_ch - 1);
            @(negedge clk);
            chk($sformatf("v%0d_done_clear", v), 32'(sweep_done_o), 32'd0);
            chk($sformatf("v%0d_idle", v), 32'(busy_o), 32'd0);
            chk($sformatf("v%0d_data_hold", v), 32'(data_o), 32'(vecs[v].chans[vecs[v].n_ch - 1]));
        end

        // Continuous scan with wrap pulses, then stop mid-DWELL
        mask_i = 8'hAA; dwell_i = 16'd1; mode_i = 1'b0;
        pulse_start();
        observe_chan("c0", 3'd0, 1, 1'b0, 1'b1);
        observe_chan("c2", 3'd2, 1, 1'b0, 1'b1);
        observe_chan("c4", 3'd4, 1, 1'b0, 1'b1);
        observe_chan("c6", 3'd6, 1, 1'b1, 1'b1);
        observe_chan("c0b", 3'd0, 1, 1'b0, 1'b1);
        dwell_i = 16'd4;
        wait_en_active("c2b");
        chk("c2b_data", 32'(data_o), 32'd2);
        @(negedge clk);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        chk("stop_en", 32'(en_o), 32'd0);
        chk("stop_busy", 32'(busy_o), 32'd0);
        chk("stop_done", 32'(sweep_done_o), 32'd0);
        @(negedge clk);
        chk("stop_stays_idle", 32'(busy_o), 32'd0);

        // All channels masked: start ignored
        mask_i = 8'hFF; mode_i = 1'b1;
        pulse_start();
        chk("ff_busy", 32'(busy_o), 32'd0);
        chk("ff_en", 32'(en_o), 32'd0);
        chk("ff_done", 32'(sweep_done_o), 32'd0);
        @(negedge clk);
        chk("ff_busy2", 32'(busy_o), 32'd0);

        // Start and stop together
        mask_i = 8'h00;
        start_i = 1'b1; stop_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; stop_i = 1'b0;
        chk("startstop_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        chk("startstop_busy2", 32'(busy_o), 32'd0);

        // Start while busy is ignored, including its mode
        mask_i = 8'b1111_1001; dwell_i = 16'd2; mode_i = 1'b1;
        pulse_start();
        chk("sb_data", 32'(data_o), 32'd1);
        chk("sb_busy", 32'(busy_o), 32'd1);
        start_i = 1'b1; mode_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        chk("sb_blank2_en", 32'(en_o), 32'd0);
        chk("sb_blank2_data", 32'(data_o), 32'd1);
        @(negedge clk);
        chk("sb_dwell1_en", 32'(en_o), 32'(EN_ACTIVE));
        @(negedge clk);
        chk("sb_dwell2_en", 32'(en_o), 32'(EN_ACTIVE));
        chk("sb_dwell2_data", 32'(data_o), 32'd1);
        @(negedge clk);
        observe_chan("sb_ch2", 3'd2, 2, 1'b1, 1'b0);
        mode_i = 1'b1;

        // Asynchronous reset mid-DWELL
        mask_i = 8'b0000_0011; dwell_i = 16'd3; mode_i = 1'b0;
        pulse_start();
        wait_en_active("ar");
        chk("ar_data_pre", 32'(data_o), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("ar_en", 32'(en_o), 32'd0);
        chk("ar_busy", 32'(busy_o), 32'd0);
        chk("ar_data", 32'(data_o), 32'd0);
        chk("ar_done", 32'(sweep_done_o), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ar_idle", 32'(busy_o), 32'd0);
        mask_i = 8'b1110_1011; dwell_i = 16'd1; mode_i = 1'b1;
        pulse_start();
        observe_chan("ar_ch2", 3'd2, 1, 1'b0, 1'b1);
        observe_chan("ar_ch4", 3'd4, 1, 1'b1, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
